// File: rtl/exe_stage_pkg.sv
// Shared definitions for the clocked execute stage.
//
// Contents:
//   state_e             - FSM state encoding (IDLE, BUSY, DONE)
//   BRANCH_PATTERN_DEF  - default instruction value that qualifies a branch
//   BRANCH_ADDR_DEF     - default target when the branch qualifies
//   FALLTHRU_ADDR_DEF   - default target otherwise
//   REGWRITE_OP         - opcode field value that qualifies a register write
//                         (only used when EXE_STAGE_REGWRITE_EN is defined)
package exe_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [31:0] BRANCH_PATTERN_DEF = 32'hCAFEBABE;
    localparam logic [31:0] BRANCH_ADDR_DEF    = 32'h0000_0000;
    localparam logic [31:0] FALLTHRU_ADDR_DEF  = 32'hDEAFBEEF;
    localparam logic [5:0]  REGWRITE_OP        = 6'b000000;

endpackage

// File: rtl/exe_latency_counter.sv
// Execute-latency down-counter.
//
// Loads LATENCY-1 on 'load', decrements while 'dec' is high and the count is
// nonzero, and reports 'zero' when the count has run out. 'clear' forces the
// count to zero and wins over load/dec.
//
// Ports:
//   clk    in  1  clock, rising edge
//   rst_n  in  1  asynchronous active-low reset (count -> 0)
//   load   in  1  load LATENCY-1
//   dec    in  1  decrement enable
//   clear  in  1  synchronous clear (highest priority)
//   zero   out 1  count == 0
module exe_latency_counter #(
    parameter  int LATENCY = 15,
    localparam int CNT_W   = $clog2(LATENCY + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    input  logic clear,
    output logic zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(LATENCY - 1);
        end else if (dec && (count != '0)) begin
            // Saturates at zero; the FSM leaves BUSY on the zero cycle.
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/exe_stage_seq.sv
// Clocked execute stage: accepts one instruction per req/ack transfer,
// decodes branch qualification and target address into holding registers,
// waits a programmable LATENCY and then presents the result with done until
// the consumer takes it with done_ack.
//
// Optional feature macro: EXE_STAGE_REGWRITE_EN
//   defined   - qual_regwrite decodes the top six instruction bits
//   undefined - qual_regwrite is tied low
//
// Handshakes:
//   input side  - a transfer happens on a rising edge where req && ack; req is
//                 held by the producer until then. ack depends on state only.
//   output side - the result is consumed on a rising edge where
//                 done && done_ack; done_ack while done is low has no effect.
//   flush aborts any state back to IDLE and clears results; it also blocks a
//   transfer in the same cycle.
//
// FSM state is observable on the ports: ack = IDLE, busy = !IDLE, done = DONE.
//
// Ports:
//   clk             in   1       clock, rising edge
//   rst_n           in   1       asynchronous active-low reset
//   req             in   1       instruction valid
//   ack             out  1       stage ready (state == IDLE)
//   instruction     in   DATA_W  instruction, sampled on transfer
//   flush           in   1       synchronous abort
//   done            out  1       result valid
//   done_ack        in   1       result consumed when done && done_ack
//   target_address  out  DATA_W  registered target
//   qual_branch     out  1       registered branch qualify
//   qual_regwrite   out  1       registered regwrite qualify
//   busy            out  1       state != IDLE
module exe_stage_seq
    import exe_stage_pkg::*;
#(
    parameter int                DATA_W         = 32,
    parameter int                LATENCY        = 15,
    parameter logic [DATA_W-1:0] BRANCH_PATTERN = DATA_W'(BRANCH_PATTERN_DEF),
    parameter logic [DATA_W-1:0] BRANCH_ADDR    = DATA_W'(BRANCH_ADDR_DEF),
    parameter logic [DATA_W-1:0] FALLTHRU_ADDR  = DATA_W'(FALLTHRU_ADDR_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    output logic              ack,
    input  logic [DATA_W-1:0] instruction,
    input  logic              flush,
    output logic              done,
    input  logic              done_ack,
    output logic [DATA_W-1:0] target_address,
    output logic              qual_branch,
    output logic              qual_regwrite,
    output logic              busy
);

    state_e state;
    state_e state_n;
    logic   accept;
    logic   cnt_zero;
    logic   branch_hit;

    assign ack        = (state == IDLE);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign accept     = req && ack && !flush;
    assign branch_hit = (instruction == BRANCH_PATTERN);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (req)      state_n = BUSY;
            BUSY: if (cnt_zero) state_n = DONE;
            DONE: if (done_ack) state_n = IDLE;
            default:            state_n = IDLE;
        endcase
        if (flush) begin
            state_n = IDLE;
        end
    end

    // -------------------------------------------------------- latency count
    // Loaded with LATENCY-1 on transfer; BUSY lasts LATENCY cycles so done
    // rises LATENCY edges after the transfer edge.
    exe_latency_counter #(
        .LATENCY (LATENCY)
    ) u_latency (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .dec   (state == BUSY),
        .clear (flush),
        .zero  (cnt_zero)
    );

    // ------------------------------------------------------ result holding
    // Results persist through IDLE until the next transfer; done qualifies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qual_branch    <= 1'b0;
            target_address <= '0;
        end else if (flush) begin
            qual_branch    <= 1'b0;
            target_address <= '0;
        end else if (accept) begin
            qual_branch    <= branch_hit;
            target_address <= branch_hit ? BRANCH_ADDR : FALLTHRU_ADDR;
        end
    end

`ifdef EXE_STAGE_REGWRITE_EN
    logic regwrite_hit;

    assign regwrite_hit = (instruction[DATA_W-1 -: 6] == REGWRITE_OP) && !branch_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qual_regwrite <= 1'b0;
        end else if (flush) begin
            qual_regwrite <= 1'b0;
        end else if (accept) begin
            qual_regwrite <= regwrite_hit;
        end
    end
`else
    assign qual_regwrite = 1'b0;
`endif

endmodule
